// File: rtl/ssp_pkg.sv
// Shared types and sizing for the SSP receive and transmit paths.
package ssp_pkg;

    localparam int unsigned SSP_DATA_W     = 8;
    localparam int unsigned SSP_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        RX_IDLE,
        RX_SHIFT
    } ssp_rx_state_e;

endpackage

// File: rtl/ssp_rx_fifo.sv
// Small show-ahead FIFO with full/empty status; a push is accepted at full
// only when a pop happens in the same cycle, otherwise it is reported as dropped.
module ssp_rx_fifo
    import ssp_pkg::*;
#(
    parameter int unsigned DataW = SSP_DATA_W,
    parameter int unsigned Depth = SSP_FIFO_DEPTH,
    parameter int unsigned PtrW  = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic             pop_i,
    output logic [DataW-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             popped_o,
    output logic             dropped_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);

    assign do_pop    = pop_i & ~empty_o;
    assign do_push   = push_i & (~full_o | do_pop);
    assign popped_o  = do_pop;
    assign dropped_o = push_i & full_o & ~do_pop;

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth is a power of two, so pointer arithmetic wraps on its own.
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ssp_rx_port.sv
// SSP receive path: synchronizes the serial pins into pclk, deserializes
// TI-style frames MSB first and buffers words in an RX FIFO for the host.
module ssp_rx_port
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_W = SSP_DATA_W,
    parameter int unsigned DEPTH  = SSP_FIFO_DEPTH,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              pclk,
    input  logic              clear_b,
    input  logic              psel,
    input  logic              pwrite,
    output logic [DATA_W-1:0] prdata,
    input  logic              sspclkin,
    input  logic              sspfssin,
    input  logic              ssprxd,
    output logic              ssprxintr,
    output logic              rx_empty,
    output logic              rx_overrun
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic fss_s1_q, fss_s2_q;
    logic rxd_s1_q, rxd_s2_q;
    logic fall;

    ssp_rx_state_e     state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              push;
    logic [DATA_W-1:0] push_word;

    logic fifo_full, fifo_empty, fifo_popped, fifo_dropped;
    logic overrun_q, overrun_d;

    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            fss_s1_q    <= 1'b0;
            fss_s2_q    <= 1'b0;
            rxd_s1_q    <= 1'b0;
            rxd_s2_q    <= 1'b0;
        end else begin
            sclk_s1_q   <= sspclkin;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            fss_s1_q    <= sspfssin;
            fss_s2_q    <= fss_s1_q;
            rxd_s1_q    <= ssprxd;
            rxd_s2_q    <= rxd_s1_q;
        end
    end

    // fss and rxd come from the same synchronizer depth as sclk, so they
    // are the values that were on the pins at the serial falling edge.
    assign fall = sclk_prev_q & ~sclk_s2_q;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        push      = 1'b0;
        push_word = {shreg_q[DATA_W-2:0], rxd_s2_q};
        if (fall) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (fss_s2_q) begin
                        state_d  = RX_SHIFT;
                        bitcnt_d = '0;
                    end
                end
                RX_SHIFT: begin
                    shreg_d  = {shreg_q[DATA_W-2:0], rxd_s2_q};
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == CNT_W'(DATA_W - 1)) begin
                        push     = 1'b1;
                        bitcnt_d = '0;
                        // fss on the last bit starts the next frame immediately
                        state_d  = fss_s2_q ? RX_SHIFT : RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b) begin
            state_q  <= RX_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    ssp_rx_fifo #(
        .DataW (DATA_W),
        .Depth (DEPTH),
        .PtrW  (PTR_W)
    ) u_fifo (
        .clk_i     (pclk),
        .rst_ni    (clear_b),
        .push_i    (push),
        .wdata_i   (push_word),
        .pop_i     (psel & ~pwrite),
        .rdata_o   (prdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .popped_o  (fifo_popped),
        .dropped_o (fifo_dropped)
    );

    // A new loss outranks a clearing read in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (fifo_popped)  overrun_d = 1'b0;
        if (fifo_dropped) overrun_d = 1'b1;
    end

    always_ff @(posedge pclk or negedge clear_b) begin
        if (!clear_b) overrun_q <= 1'b0;
        else          overrun_q <= overrun_d;
    end

    assign ssprxintr  = fifo_full;
    assign rx_empty   = fifo_empty;
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_ssp_rx_port.sv
// Directed bench for ssp_rx_port: serial frames driven on the pins, FIFO
// contents and status checked against hand-computed values.
module tb_ssp_rx_port;

    logic       pclk = 1'b0;
    logic       clear_b;
    logic       psel;
    logic       pwrite;
    logic [7:0] prdata;
    logic       sspclkin;
    logic       sspfssin;
    logic       ssprxd;
    logic       ssprxintr;
    logic       rx_empty;
    logic       rx_overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] popped;

    always #5 pclk = ~pclk;

    ssp_rx_port dut (
        .pclk       (pclk),
        .clear_b    (clear_b),
        .psel       (psel),
        .pwrite     (pwrite),
        .prdata     (prdata),
        .sspclkin   (sspclkin),
        .sspfssin   (sspfssin),
        .ssprxd     (ssprxd),
        .ssprxintr  (ssprxintr),
        .rx_empty   (rx_empty),
        .rx_overrun (rx_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // One serial bit: data changes on the rising edge, sampled on the falling
    // edge; with rd set, a host read lands on the edge that pushes this bit's word.
    task automatic send_bit(input logic d, input logic fs, input logic rd);
        sspclkin = 1'b1;
        ssprxd   = d;
        sspfssin = fs;
        tick(4);
        sspclkin = 1'b0;
        if (rd) begin
            tick(2);
            psel   = 1'b1;
            pwrite = 1'b0;
            popped = prdata;
            tick(1);
            psel = 1'b0;
            tick(1);
        end else begin
            tick(4);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input logic fs_last, input logic rd_last);
        for (int i = 7; i >= 0; i--)
            send_bit(w[i], (i == 0) && fs_last, (i == 0) && rd_last);
        sspfssin = 1'b0;
    endtask

    task automatic preamble();
        send_bit(1'b0, 1'b1, 1'b0);
    endtask

    task automatic read_check(input string tag, input logic [7:0] exp);
        check(tag, prdata, exp);
        psel   = 1'b1;
        pwrite = 1'b0;
        tick(1);
        psel = 1'b0;
    endtask

    task automatic do_reset();
        clear_b = 1'b0;
        tick(2);
        clear_b = 1'b1;
        tick(1);
    endtask

    initial begin
        psel     = 1'b0;
        pwrite   = 1'b0;
        sspclkin = 1'b0;
        sspfssin = 1'b0;
        ssprxd   = 1'b0;
        popped   = '0;
        clear_b  = 1'b1;
        tick(1);
        do_reset();
        check("rst_empty", rx_empty, 1);
        check("rst_intr", ssprxintr, 0);
        check("rst_prdata", prdata, 8'h00);

        // Load one word, then reset with data present.
        preamble();
        send_word(8'hA5, 1'b0, 1'b0);
        check("pre_rst_empty", rx_empty, 0);
        do_reset();
        check("rst2_prdata", prdata, 8'h00);
        check("rst2_empty", rx_empty, 1);
        check("rst2_intr", ssprxintr, 0);
        check("rst2_ovr", rx_overrun, 0);

        // Single frame; the bit task leaves 4 pclk after the last falling edge.
        preamble();
        send_word(8'hA5, 1'b0, 1'b0);
        check("a5_empty", rx_empty, 0);
        check("a5_intr", ssprxintr, 0);
        psel   = 1'b1;
        pwrite = 1'b1;
        tick(1);
        psel   = 1'b0;
        pwrite = 1'b0;
        check("wr_ignored", prdata, 8'hA5);
        read_check("a5_data", 8'hA5);
        check("a5_empty_after", rx_empty, 1);
        check("a5_prdata_after", prdata, 8'h00);
        psel = 1'b1;
        tick(1);
        psel = 1'b0;
        check("rd_empty_noop", rx_empty, 1);

        // Back-to-back frames with fss on each LSB but the last.
        preamble();
        send_word(8'hAA, 1'b1, 1'b0);
        check("b2b_intr_1", ssprxintr, 0);
        send_word(8'hF0, 1'b1, 1'b0);
        send_word(8'h55, 1'b1, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0);
        check("b2b_intr_4", ssprxintr, 1);
        check("b2b_ovr", rx_overrun, 0);
        check("b2b_head", prdata, 8'hAA);

        // Fifth frame while full is dropped.
        preamble();
        send_word(8'hFF, 1'b0, 1'b0);
        check("ovr_set", rx_overrun, 1);
        check("ovr_intr", ssprxintr, 1);
        read_check("ovr_rd0", 8'hAA);
        check("ovr_clr", rx_overrun, 0);
        check("ovr_intr_clr", ssprxintr, 0);

        // Refill, then a read coinciding with the push of 3C at full.
        preamble();
        send_word(8'h12, 1'b0, 1'b0);
        check("refill_intr", ssprxintr, 1);
        preamble();
        send_word(8'h3C, 1'b0, 1'b1);
        check("coinc_popped", popped, 8'hF0);
        check("coinc_ovr", rx_overrun, 0);
        check("coinc_intr", ssprxintr, 1);
        read_check("coinc_rd1", 8'h55);
        read_check("coinc_rd2", 8'h0F);
        read_check("coinc_rd3", 8'h12);
        read_check("coinc_rd4", 8'h3C);
        check("coinc_empty", rx_empty, 1);

        // Reset after 4 bits of a frame discards the partial word.
        preamble();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        do_reset();
        tick(8);
        check("mid_rst_empty", rx_empty, 1);
        preamble();
        send_word(8'h81, 1'b0, 1'b0);
        check("post_rst_empty", rx_empty, 0);
        read_check("post_rst_data", 8'h81);
        check("post_rst_drained", rx_empty, 1);
        check("post_rst_ovr", rx_overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
